// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C controller APB front end.
// Contents: register address map, prescaler reset value, the APB-side FSM
// state type and a helper that encodes which direction each register allows.
package i2c_pkg;

    localparam int unsigned ADDR_CMD      = 32'd1;
    localparam int unsigned ADDR_SADDR    = 32'd2;
    localparam int unsigned ADDR_STATUS   = 32'd3;
    localparam int unsigned ADDR_TXDATA   = 32'd4;
    localparam int unsigned ADDR_RXDATA   = 32'd5;
    localparam int unsigned ADDR_PRESCALE = 32'd6;

    localparam logic [7:0] PRESCALE_RST = 8'h04;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_WAIT_TX = 2'd2
    } apb_state_t;

    // True when the address exists and supports the requested direction.
    function automatic logic reg_access_ok(input logic [31:0] addr, input logic write);
        logic ok;
        case (addr)
            ADDR_CMD, ADDR_SADDR, ADDR_TXDATA, ADDR_PRESCALE: ok = write;
            ADDR_STATUS, ADDR_RXDATA:                         ok = ~write;
            default:                                          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/i2c_apb_decode.sv
// Combinational classification of an APB address/direction pair.
// Ports:
//   i_addr, i_write : address and direction of the setup cycle
//   o_ok / o_err    : access is legal / must get an error response
//   o_is_tx         : legal write to TX_DATA
//   o_is_rx         : legal read of RX_DATA
//   o_is_cfg        : legal write to CMD, SLAVE_ADDR or PRESCALE
module i2c_apb_decode
    import i2c_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_write,
    output logic                  o_ok,
    output logic                  o_err,
    output logic                  o_is_tx,
    output logic                  o_is_rx,
    output logic                  o_is_cfg
);

    logic [31:0] w_addr;

    // Classify the access against the register map.
    always_comb begin
        w_addr   = 32'(i_addr);
        o_ok     = reg_access_ok(w_addr, i_write);
        o_err    = ~o_ok;
        o_is_tx  = o_ok & i_write & (w_addr == ADDR_TXDATA);
        o_is_rx  = o_ok & ~i_write & (w_addr == ADDR_RXDATA);
        o_is_cfg = o_ok & i_write & ((w_addr == ADDR_CMD) || (w_addr == ADDR_SADDR) ||
                                     (w_addr == ADDR_PRESCALE));
    end

endmodule

// File: rtl/i2c_apb_slave.sv
// APB3 slave front end of the I2C controller.
// Ports:
//   pclk/preset                      : clock, synchronous active-high reset
//   pselx/penable/pwrite/paddr/pwdata: APB request
//   prdata/pready/pslverr            : registered APB response
//   cmd_reg/cmd_valid                : command register and its write pulse
//   slave_addr_reg/prescale_reg      : configuration registers
//   status_in                        : core status (read at STATUS)
//   tx_data/tx_push/tx_full          : TX FIFO write side
//   rx_data/rx_pop/rx_empty          : RX FIFO read side (show-ahead)
// A setup cycle is classified at its own clock edge; the access phase then
// sees pready=1 immediately, or after wait states while the TX FIFO is full.
module i2c_apb_slave
    import i2c_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int WAIT_MAX   = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  pselx,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [DATA_WIDTH-1:0] cmd_reg,
    output logic                  cmd_valid,
    output logic [DATA_WIDTH-1:0] slave_addr_reg,
    output logic [DATA_WIDTH-1:0] prescale_reg,
    input  logic [DATA_WIDTH-1:0] status_in,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_push,
    input  logic                  tx_full,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_pop,
    input  logic                  rx_empty
);

    localparam int            CW       = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    apb_state_t            r_state;
    apb_state_t            w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_pready_nxt;
    logic                  w_pslverr_nxt;
    logic                  w_capture;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_is_tx;
    logic                  r_is_rx;
    logic                  r_is_cfg;
    logic                  w_ok;
    logic                  w_err;
    logic                  w_is_tx;
    logic                  w_is_rx;
    logic                  w_is_cfg;
    logic                  w_commit;

    i2c_apb_decode #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_decode (
        .i_addr   (paddr),
        .i_write  (pwrite),
        .o_ok     (w_ok),
        .o_err    (w_err),
        .o_is_tx  (w_is_tx),
        .o_is_rx  (w_is_rx),
        .o_is_cfg (w_is_cfg)
    );

    // FSM state register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, wait counter and next APB response.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pready_nxt  = 1'b0;
        w_pslverr_nxt = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (pselx && !penable) begin
                    w_capture = 1'b1;
                    if (w_is_tx && tx_full) begin
                        w_state_nxt = ST_WAIT_TX;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt   = ST_ACCESS;
                        w_pready_nxt  = 1'b1;
                        // An empty RX FIFO turns a legal read into an error.
                        w_pslverr_nxt = w_err | (w_is_rx & rx_empty);
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                w_state_nxt = ST_IDLE;
            end
            ST_WAIT_TX: begin
                if (!pselx) begin
                    w_state_nxt = ST_IDLE;
                end else if (!tx_full) begin
                    w_state_nxt  = ST_ACCESS;
                    w_pready_nxt = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = ST_ACCESS;
                    w_pready_nxt  = 1'b1;
                    w_pslverr_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read data selected at the setup edge; errors read as zero.
    always_comb begin
        w_rd_data = '0;
        if (w_ok && !pwrite) begin
            if (w_is_rx) begin
                w_rd_data = rx_empty ? '0 : rx_data;
            end else begin
                w_rd_data = status_in;
            end
        end else begin
            w_rd_data = '0;
        end
    end

    // Side effects happen only in a healthy access phase; pslverr is the
    // registered error of this transfer, so it also blocks timed-out pushes.
    always_comb begin
        w_commit  = (r_state == ST_ACCESS) & pselx & penable & ~pslverr & ~preset;
        cmd_valid = w_commit & r_is_cfg & (32'(r_addr) == ADDR_CMD);
        tx_push   = w_commit & r_is_tx & ~tx_full;
        rx_pop    = w_commit & r_is_rx & ~rx_empty;
        tx_data   = pwdata;
    end

    // Wait counter, APB response and captured transfer attributes.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_cnt    <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            prdata   <= '0;
            r_addr   <= '0;
            r_is_tx  <= 1'b0;
            r_is_rx  <= 1'b0;
            r_is_cfg <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            pready  <= w_pready_nxt;
            pslverr <= w_pslverr_nxt;
            if (w_capture) begin
                r_addr   <= paddr;
                r_is_tx  <= w_is_tx;
                r_is_rx  <= w_is_rx;
                r_is_cfg <= w_is_cfg;
                if (!pwrite) begin
                    prdata <= w_rd_data;
                end
            end
        end
    end

    // Configuration registers commit at the edge ending the access phase.
    always_ff @(posedge pclk) begin
        if (preset) begin
            cmd_reg        <= '0;
            slave_addr_reg <= '0;
            prescale_reg   <= DATA_WIDTH'(PRESCALE_RST);
        end else if (w_commit && r_is_cfg) begin
            if (32'(r_addr) == ADDR_CMD) begin
                cmd_reg <= pwdata;
            end
            if (32'(r_addr) == ADDR_SADDR) begin
                slave_addr_reg <= pwdata;
            end
            if (32'(r_addr) == ADDR_PRESCALE) begin
                prescale_reg <= pwdata;
            end
        end
    end

endmodule

// File: doc/i2c_apb_slave.md
Name: i2c_apb_slave

Overview:
APB3 slave front end for the I2C controller. It sits directly behind the APB bus and ahead of the I2C core.
- Decodes `paddr` and generates `pready`/`pslverr` with a registered handshake.
- Holds the write-only configuration registers.
- Turns accesses to the data registers into push/pop strobes on the core's external TX and RX FIFOs.
- Returns status and RX data on `prdata`.

Parameters:
- ADDR_WIDTH, 8, width of `paddr`.
- DATA_WIDTH, 8, width of `pwdata`, `prdata` and all registers.
- WAIT_MAX, 16, maximum wait states on a TX write while `tx_full`, before an error response is returned.

Ports:
- pclk  in  1  APB clock; everything is clocked on its rising edge.
- preset  in  1  reset; synchronous, active-high.
- pselx  in  1  slave select.
- penable  in  1  access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  register address.
- pwdata  in  DATA_WIDTH  write data.
- prdata  out  DATA_WIDTH  read data; registered.
- pready  out  1  transfer complete; registered.
- pslverr  out  1  error flag, valid only while `pready`=1.
- cmd_reg  out  DATA_WIDTH  command register (addr 1).
- cmd_valid  out  1  one-cycle pulse when `cmd_reg` is written.
- slave_addr_reg  out  DATA_WIDTH  target address register (addr 2).
- prescale_reg  out  DATA_WIDTH  SCL prescaler register (addr 6).
- status_in  in  DATA_WIDTH  core status, returned on reads of addr 3.
- tx_data  out  DATA_WIDTH  TX FIFO write data.
- tx_push  out  1  TX FIFO push strobe.
- tx_full  in  1  TX FIFO full.
- rx_data  in  DATA_WIDTH  RX FIFO head; show-ahead.
- rx_pop  out  1  RX FIFO pop strobe.
- rx_empty  in  1  RX FIFO empty.

Behaviour:
- Register map:
  - 1 CMD (W)
  - 2 SLAVE_ADDR (W)
  - 3 STATUS (R)
  - 4 TX_DATA (W)
  - 5 RX_DATA (R)
  - 6 PRESCALE (W)
  - Every other address is unmapped.
- Reset (synchronous, `preset`=1): FSM to IDLE. `prdata`, `pready`, `pslverr`, `cmd_reg`, `cmd_valid`, `slave_addr_reg`, `tx_push`, `rx_pop` and the wait counter all go to 0. `prescale_reg` goes to 0x04.
- Reset takes priority over any transfer in flight. A transfer aborted by reset produces no strobe.
- FSM states: IDLE, ACCESS, WAIT_TX.
- IDLE:
  - Setup cycle T0 (`pselx`=1, `penable`=0) is classified at the T0 edge.
  - Any class other than a TX write while full moves to ACCESS, with `pready`=1 in T1 (zero wait states).
  - TX write with `tx_full`=1 moves to WAIT_TX, with `pready`=0 and the counter cleared.
- ACCESS (`pready`=1 for exactly one cycle):
  - Writes commit in this cycle: the register updates at the edge ending T1.
  - `cmd_valid` and `tx_push` are asserted combinationally in T1. `tx_data` equals `pwdata`.
  - On an RX read, `rx_pop` is asserted in T1.
  - Then return to IDLE. A new setup cycle is accepted in the very next cycle, so back-to-back transfers take 2 cycles each.
- WAIT_TX:
  - Each cycle with `tx_full`=1 increments the counter.
  - When `tx_full`=0, go to ACCESS with `pready`=1 next cycle and push there.
  - When the counter reaches WAIT_MAX-1 with `tx_full` still 1, go to ACCESS with `pslverr`=1 and no push.
- Read data: `prdata` is loaded at the T0 edge.
  - STATUS returns `status_in`.
  - RX_DATA returns `rx_data`.
  - Any other address returns 0.
  - `prdata` holds its value until the next read.
- Error responses (`pslverr`=1 with `pready`, no side effect):
  - Write to address 3 or 5.
  - Read from address 1, 2, 4 or 6.
  - Access to an unmapped address.
  - Read of RX_DATA with `rx_empty`=1; `prdata` is 0 and there is no pop.
  - TX timeout.
- `pselx` dropping mid-transfer (protocol violation): return to IDLE next cycle with no strobe. `pready` is never asserted without a preceding setup cycle.
- Strobe guarantees: `tx_push` and `rx_pop` never assert while `tx_full` or `rx_empty` (respectively) is 1. At most one strobe per transfer.

Decomposition:
- Package `i2c_pkg` holds:
  - Register address constants: `ADDR_CMD`=1, `ADDR_SADDR`=2, `ADDR_STATUS`=3, `ADDR_TXDATA`=4, `ADDR_RXDATA`=5, `ADDR_PRESCALE`=6.
  - `PRESCALE_RST`=0x04.
  - The FSM state enum `apb_state_t`.
  - A function `reg_access_ok(addr, write)` encoding the R/W map.
- One sub-module, `i2c_apb_decode`, is combinational: address/direction classification to {ok, err, is_tx, is_rx, is_cfg}.
- The FSM and registers stay in the top level.

Test Plan:
- Write 0x5A to addr 2 (setup T0, access T1) -> `pready`=1 in T1, `pslverr`=0, `slave_addr_reg`=0x5A from T2. Repeat with addr 6 / 0x20 -> `prescale_reg`=0x20.
- Write 0x03 to addr 1 -> `cmd_valid` high in T1 only, `cmd_reg`=0x03. Back-to-back write follows with no idle cycle.
- Read addr 5 with `rx_data`=0xA7, `rx_empty`=0 -> `prdata`=0xA7, `rx_pop` for one cycle. With `rx_empty`=1 -> `prdata`=0, `pslverr`=1, no pop.
- TX write 0x11 with `tx_full`=1, released after 3 cycles -> 3 wait states, then `pready`=1 with `tx_push` and `tx_data`=0x11. Held full for 20 cycles -> `pready` with `pslverr`=1 after WAIT_MAX cycles, no push.
- Write to addr 3, read addr 4, access addr 7 -> each gives `pready`=1, `pslverr`=1, no register change.
- Assert `preset` during WAIT_TX -> next cycle all outputs 0, `prescale_reg`=0x04, no push.
